// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bus: CPU port, debug port and memory port.
// The arbiter takes the slave side; the environment takes the master side.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_lb;
    logic        cpu_lbu;
    logic        cpu_sb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    logic        wren;
    logic        lb;
    logic        lbu;
    logic        sb;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport slave (
        input  cpu_req, cpu_we, cpu_lb, cpu_lbu, cpu_sb,
        input  cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output wren, lb, lbu, sb, address, writeData,
        input  readData
    );

    modport master (
        output cpu_req, cpu_we, cpu_lb, cpu_lbu, cpu_sb,
        output cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  wren, lb, lbu, sb, address, writeData,
        output readData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU parks on the port, debug/loader gets word
// accesses when the CPU is idle or has been granted too long in a row.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave mem_if
);
    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_OWN = 1'b1
    } own_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    own_e        state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        cpu_own;
    logic        cpu_ack;
    logic        dbg_ack;
    logic        dbg_elig;

    always_comb begin
        cpu_own     = (state_q == CPU_OWN);
        cpu_ack     = mem_if.cpu_req & cpu_own & ~rst;
        dbg_ack     = mem_if.dbg_req & ~cpu_own & ~rst;
        dbg_elig    = mem_if.dbg_req & ~dbg_ack;
        starve_d    = starve_q;
        state_d     = CPU_OWN;
        dbg_rdata_d = dbg_rdata_q;

        if (dbg_ack || !mem_if.dbg_req) begin
            starve_d = '0;
        end else if (cpu_ack && starve_q != LIMIT) begin
            starve_d = starve_q + 3'd1;
        end

        // Count includes this cycle's grant: DBG follows exactly LIMIT grants
        if (dbg_elig && (!mem_if.cpu_req || starve_d == LIMIT)) begin
            state_d = DBG_OWN;
        end

        if (dbg_ack && !mem_if.dbg_we) begin
            dbg_rdata_d = mem_if.readData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CPU_OWN;
            starve_q    <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_if.address   = cpu_own ? mem_if.cpu_addr  : mem_if.dbg_addr;
    assign mem_if.writeData = cpu_own ? mem_if.cpu_wdata : mem_if.dbg_wdata;

    assign mem_if.wren = ~rst & (cpu_own ? (mem_if.cpu_we & mem_if.cpu_req)
                                         : (mem_if.dbg_we & mem_if.dbg_req));
    assign mem_if.lb   = ~rst & cpu_own & mem_if.cpu_lb  & mem_if.cpu_req;
    assign mem_if.lbu  = ~rst & cpu_own & mem_if.cpu_lbu & mem_if.cpu_req;
    assign mem_if.sb   = ~rst & cpu_own & mem_if.cpu_sb  & mem_if.cpu_req;

    assign mem_if.cpu_rdata = mem_if.readData;
    assign mem_if.cpu_stall = mem_if.cpu_req & ~cpu_own & ~rst;
    assign mem_if.dbg_ack   = dbg_ack;
    assign mem_if.dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter with a word memory model and
// scoreboard queues for CPU stores and debug reads.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    dmem_arbiter_if ifc ();

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (ifc.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [255:0] vld;
    logic [7:0]   widx;

    assign widx = ifc.address[9:2];
    assign ifc.readData = vld[widx] ? mem[widx] : (ifc.address ^ 32'h5A5A_0000);

    always @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (ifc.wren && !ifc.sb) begin
            mem[widx]  <= ifc.writeData;
            vld[widx]  <= 1'b1;
        end
    end

    logic [63:0] cq [$];
    logic [31:0] dq [$];
    logic [63:0] cexp;
    logic [31:0] dexp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.cpu_req   = 1'b0;
        ifc.cpu_we    = 1'b0;
        ifc.cpu_lb    = 1'b0;
        ifc.cpu_lbu   = 1'b0;
        ifc.cpu_sb    = 1'b0;
        ifc.cpu_addr  = '0;
        ifc.cpu_wdata = '0;
        ifc.dbg_req   = 1'b0;
        ifc.dbg_we    = 1'b0;
        ifc.dbg_addr  = '0;
        ifc.dbg_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_sb = 1'b1;
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); #4;
            n_chk++; if (ifc.wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %b want 0", ifc.wren); end
            n_chk++; if (ifc.sb !== 1'b0) begin n_fail++; $display("FAIL rst_sb got %b want 0", ifc.sb); end
            n_chk++; if (ifc.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", ifc.dbg_ack); end
            n_chk++; if (ifc.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", ifc.cpu_stall); end
        end
        tick();
        rst = 1'b0;
        idle();
        ifc.cpu_req = 1'b1;
        #4;
        n_chk++; if (ifc.dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", ifc.dbg_rdata); end
        n_chk++; if (ifc.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_own got stall %b want 0", ifc.cpu_stall); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        for (int i = 0; i < 2; i++) begin
            tick();
            idle();
            a = 32'h10 + 32'(i * 4);
            d = 32'h1111_1111 * 32'(i + 1);
            ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1;
            ifc.cpu_addr = a; ifc.cpu_wdata = d;
            cq.push_back({a, d});
            #4;
            n_chk++;
            if (ifc.wren === 1'b1 && ifc.cpu_stall === 1'b0 && cq.size() > 0) begin
                cexp = cq.pop_front();
                if ({ifc.address, ifc.writeData} !== cexp) begin
                    n_fail++;
                    $display("FAIL b2b_store got %h/%h want %h/%h", ifc.address, ifc.writeData, cexp[63:32], cexp[31:0]);
                end
            end else begin
                n_fail++;
                $display("FAIL b2b_ack got wren=%b stall=%b want 1/0", ifc.wren, ifc.cpu_stall);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            idle();
            ifc.cpu_req = 1'b1;
            ifc.cpu_addr = 32'h10 + 32'(i * 4);
            #4;
            n_chk++; if (ifc.cpu_rdata !== 32'h1111_1111 * 32'(i + 1)) begin n_fail++; $display("FAIL cpu_load got %h want %h", ifc.cpu_rdata, 32'h1111_1111 * 32'(i + 1)); end
            n_chk++; if (ifc.wren !== 1'b0) begin n_fail++; $display("FAIL cpu_load_wren got %b want 0", ifc.wren); end
        end
    endtask

    task automatic test_dbg_rw();
        tick(); idle();
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1;
        ifc.dbg_addr = 32'h20; ifc.dbg_wdata = 32'hDEAD_BEEF;
        #4;
        n_chk++; if (ifc.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL dbgw_lat got ack %b want 0", ifc.dbg_ack); end
        tick(); #4;
        n_chk++; if (ifc.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbgw_ack got %b want 1", ifc.dbg_ack); end
        n_chk++; if ({ifc.wren, ifc.address} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL dbgw_port got %b/%h want 1/20", ifc.wren, ifc.address); end
        tick(); idle();
        tick();
        ifc.dbg_req = 1'b1; ifc.dbg_addr = 32'h20;
        dq.push_back(32'hDEAD_BEEF);
        #4;
        n_chk++; if (ifc.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL dbgr_lat got ack %b want 0", ifc.dbg_ack); end
        tick(); #4;
        n_chk++; if (ifc.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL dbgr_ack got %b want 1", ifc.dbg_ack); end
        n_chk++; if (ifc.dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL dbgr_early got %h want 0", ifc.dbg_rdata); end
        tick(); idle();
        ifc.cpu_req = 1'b1; ifc.cpu_addr = 32'h80;
        #4;
        n_chk++;
        if (dq.size() > 0) begin
            dexp = dq.pop_front();
            if (ifc.dbg_rdata !== dexp) begin n_fail++; $display("FAIL dbgr_data got %h want %h", ifc.dbg_rdata, dexp); end
        end else begin
            n_fail++; $display("FAIL dbgr_sb got empty queue want entry");
        end
        n_chk++; if (ifc.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dbgr_back got stall %b want 0", ifc.cpu_stall); end
        tick(); idle(); #4;
        n_chk++; if (ifc.dbg_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dbgr_hold got %h want deadbeef", ifc.dbg_rdata); end
    endtask

    task automatic test_no_regrant();
        tick(); idle();
        ifc.dbg_req = 1'b1; ifc.dbg_addr = 32'h20;
        tick(); #4;
        n_chk++; if (ifc.dbg_ack !== 1'b1) begin n_fail++; $display("FAIL regr_ack got %b want 1", ifc.dbg_ack); end
        tick(); #4;
        n_chk++; if (ifc.dbg_ack !== 1'b0) begin n_fail++; $display("FAIL regr_again got %b want 0", ifc.dbg_ack); end
        tick(); idle();
        ifc.dbg_we = 1'b1; ifc.dbg_addr = 32'h28;
        #4;
        n_chk++; if ({ifc.wren, ifc.dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL noreq got wren/ack %b%b want 00", ifc.wren, ifc.dbg_ack); end
        tick(); idle();
    endtask

    task automatic test_starve();
        for (int i = 0; i < 7; i++) begin
            tick(); idle();
            ifc.cpu_req = 1'b1;
            ifc.cpu_addr = 32'h100 + 32'(i * 4);
            ifc.dbg_req = (i < 5);
            ifc.dbg_addr = 32'h44;
            if (i == 4) dq.push_back(32'h5A5A_0044);
            #4;
            if (i == 4) begin
                n_chk++; if ({ifc.cpu_stall, ifc.dbg_ack} !== 2'b11) begin n_fail++; $display("FAIL starve_grant got stall/ack %b%b want 11", ifc.cpu_stall, ifc.dbg_ack); end
                n_chk++; if (ifc.address !== 32'h44) begin n_fail++; $display("FAIL starve_addr got %h want 44", ifc.address); end
            end else begin
                n_chk++; if ({ifc.cpu_stall, ifc.dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL starve_cpu%0d got stall/ack %b%b want 00", i, ifc.cpu_stall, ifc.dbg_ack); end
            end
            if (i == 5) begin
                n_chk++;
                if (dq.size() > 0) begin
                    dexp = dq.pop_front();
                    if (ifc.dbg_rdata !== dexp) begin n_fail++; $display("FAIL starve_data got %h want %h", ifc.dbg_rdata, dexp); end
                end else begin
                    n_fail++; $display("FAIL starve_sb got empty queue want entry");
                end
            end
        end
    endtask

    task automatic test_collision();
        tick(); idle();
        ifc.dbg_req = 1'b1; ifc.dbg_we = 1'b1;
        ifc.dbg_addr = 32'h30; ifc.dbg_wdata = 32'hCAFE_F00D;
        tick();
        ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1; ifc.cpu_sb = 1'b1;
        ifc.cpu_addr = 32'h34; ifc.cpu_wdata = 32'h1234_5678;
        #4;
        n_chk++; if ({ifc.dbg_ack, ifc.cpu_stall} !== 2'b11) begin n_fail++; $display("FAIL col_own got ack/stall %b%b want 11", ifc.dbg_ack, ifc.cpu_stall); end
        n_chk++; if ({ifc.wren, ifc.sb, ifc.address, ifc.writeData} !== {2'b10, 32'h30, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL col_port got %b%b %h %h want 10 30 cafef00d", ifc.wren, ifc.sb, ifc.address, ifc.writeData); end
        tick();
        ifc.dbg_req = 1'b0;
        #4;
        n_chk++; if (ifc.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL col_release got stall %b want 0", ifc.cpu_stall); end
        n_chk++; if ({ifc.wren, ifc.sb, ifc.address} !== {2'b11, 32'h34}) begin n_fail++; $display("FAIL col_cpu got %b%b %h want 11 34", ifc.wren, ifc.sb, ifc.address); end
        tick(); idle();
    endtask

    task automatic test_reset_mid();
        tick(); idle();
        ifc.dbg_req = 1'b1; ifc.dbg_addr = 32'h20;
        tick();
        rst = 1'b1;
        ifc.cpu_req = 1'b1;
        #4;
        n_chk++; if ({ifc.dbg_ack, ifc.wren, ifc.cpu_stall} !== 3'b000) begin n_fail++; $display("FAIL mid_rst got ack/wren/stall %b%b%b want 000", ifc.dbg_ack, ifc.wren, ifc.cpu_stall); end
        tick();
        rst = 1'b0;
        #4;
        n_chk++; if ({ifc.dbg_ack, ifc.cpu_stall} !== 2'b00) begin n_fail++; $display("FAIL mid_own got ack/stall %b%b want 00", ifc.dbg_ack, ifc.cpu_stall); end
        n_chk++; if (ifc.dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata got %h want 0", ifc.dbg_rdata); end
        tick(); idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_back_to_back();
        test_dbg_rw();
        test_no_regrant();
        test_starve();
        test_collision();
        test_reset_mid();
        n_chk++; if (cq.size() + dq.size() != 0) begin n_fail++; $display("FAIL sb_drain got %0d left want 0", cq.size() + dq.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets the consecutive CPU grants allowed while DBG waits; legal range 1-7.
REQ-002 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cpu_req  in  1  CPU memory-stage access valid; new access each cycle it is high.
REQ-006 cpu_we, cpu_lb, cpu_lbu, cpu_sb  in  1 each  CPU write enable and byte-mode strobes.
REQ-007 cpu_addr, cpu_wdata  in  32 each  CPU address and store data.
REQ-008 cpu_rdata  out  32  load data to CPU.
REQ-009 cpu_stall  out  1  CPU must hold its access this cycle.
REQ-010 dbg_req, dbg_we  in  1 each  debug/loader word access request and write enable; request held until ack.
REQ-011 dbg_addr, dbg_wdata  in  32 each  debug address and write data.
REQ-012 dbg_ack  out  1  debug access performed this cycle.
REQ-013 dbg_rdata  out  32  registered debug read data.
REQ-014 wren, lb, lbu, sb  out  1 each  data-memory write enable and byte strobes.
REQ-015 address, writeData  out  32 each  data-memory address and write data.
REQ-016 readData  in  32  data-memory combinational read data.

Function
REQ-017 Ownership FSM shall have two states, CPU_OWN (park state) and DBG_OWN, updated only on the rising clk edge.
REQ-018 cpu_ack (internal) shall be cpu_req AND state==CPU_OWN; dbg_ack shall be dbg_req AND state==DBG_OWN, both combinational.
REQ-019 In CPU_OWN the memory port shall carry cpu_addr, cpu_wdata, wren=cpu_we&cpu_req, lb/lbu/sb = cpu strobe & cpu_req.
REQ-020 In DBG_OWN the memory port shall carry dbg_addr, dbg_wdata, wren=dbg_we&dbg_req, lb=lbu=sb=0 (word access only).
REQ-021 cpu_rdata shall equal readData combinationally in every cycle.
REQ-022 cpu_stall shall be cpu_req AND state!=CPU_OWN.
REQ-023 dbg_eligible shall be dbg_req AND NOT dbg_ack; a just-acked DBG request is never re-granted the following cycle.
REQ-024 Next state shall be DBG_OWN when dbg_eligible AND (NOT cpu_req OR starve_cnt==STARVE_LIMIT); otherwise CPU_OWN.
REQ-025 starve_cnt (3 bits) shall clear when dbg_ack or NOT dbg_req; else increment on cpu_ack, saturating at STARVE_LIMIT.
REQ-026 dbg_rdata shall load readData on the edge ending a cycle with dbg_ack AND NOT dbg_we, and hold otherwise.
REQ-027 CPU access latency shall be zero while parked; DBG access latency shall be at least one cycle after dbg_req rises.
REQ-028 cpu_req rising while state==DBG_OWN shall stall the CPU exactly that one cycle, then return to CPU_OWN.
REQ-029 Requests with req low shall produce no write and no ack regardless of state.

Reset
REQ-030 rst=1 at an edge shall set state=CPU_OWN, starve_cnt=0, dbg_rdata=0, overriding every other update including mid-DBG ownership.
REQ-031 While rst=1, wren, lb, lbu, sb, dbg_ack shall be 0 and cpu_stall shall be 0.

Verification
REQ-032 Reset: rst=1 two cycles with cpu_req=1, dbg_req=1 -> wren=0, dbg_ack=0, cpu_stall=0; after release state=CPU_OWN, dbg_rdata=0.
REQ-033 CPU back-to-back stores: cpu_req=1, cpu_we=1, addr 0x10 then 0x14, dbg_req=0 -> wren=1 both cycles, address follows, cpu_stall=0.
REQ-034 DBG read: memory[0x20]=0xDEADBEEF, cpu_req=0, dbg_req=1 addr 0x20 at cycle 0 -> dbg_ack=1 at cycle 1, dbg_rdata=0xDEADBEEF from cycle 2, state CPU_OWN at cycle 2.
REQ-035 Starvation: cpu_req=1 continuously, dbg_req raised cycle 0, STARVE_LIMIT=4 -> CPU acked cycles 0-3, cpu_stall=1 and dbg_ack=1 at cycle 4, CPU acked again from cycle 5.
REQ-036 Collision: cpu_req=0, dbg_req=1 cycle 0; cpu_req=1 from cycle 1 -> cycle 1 dbg_ack=1, cpu_stall=1, wren from dbg; cycle 2 cpu_stall=0.
REQ-037 Reset mid-operation: rst=1 in a DBG_OWN cycle -> next cycle CPU_OWN, starve_cnt=0, dbg_rdata=0, no dbg_ack.
